// File: rtl/mandelbrot_scan.sv
// mandelbrot_scan: frame sequencer for the fixed-point Mandelbrot core.
//
// Walks an H_RES x V_RES grid in raster order. For each pixel it presents the
// complex coordinate to the core with a one-cycle start pulse, waits for the
// core's done pulse, then writes the iteration count to the framebuffer over a
// valid/ready port. Coordinates are stepped incrementally (no multiplier) and
// wrap as FP_WIDTH-bit two's complement.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a frame (only honoured while idle)
//   x_start, y_start, step  signed coordinate of pixel (0,0) and pixel pitch
//   busy, done              frame in progress / one-cycle frame-complete pulse
//   calc_start, calc_re,
//   calc_im                 request to the core
//   calc_done, calc_iter    result from the core
//   fb_we, fb_addr,
//   fb_data, fb_ready       framebuffer write port (valid/ready)
module mandelbrot_scan #(
   parameter int unsigned FP_WIDTH = 25,
   parameter int unsigned FP_INT   = 4,
   parameter int unsigned ITERW    = 8,
   parameter int unsigned H_RES    = 320,
   parameter int unsigned V_RES    = 180,
   parameter int unsigned ADDRW    = $clog2(H_RES * V_RES)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [FP_WIDTH-1:0] x_start,
   input  logic [FP_WIDTH-1:0] y_start,
   input  logic [FP_WIDTH-1:0] step,
   output logic                busy,
   output logic                done,
   output logic                calc_start,
   output logic [FP_WIDTH-1:0] calc_re,
   output logic [FP_WIDTH-1:0] calc_im,
   input  logic                calc_done,
   input  logic [ITERW-1:0]    calc_iter,
   output logic                fb_we,
   output logic [ADDRW-1:0]    fb_addr,
   output logic [ITERW-1:0]    fb_data,
   input  logic                fb_ready
);

   localparam int unsigned PXW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int unsigned PYW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [PXW-1:0] PX_LAST = PXW'(H_RES - 1);
   localparam logic [PYW-1:0] PY_LAST = PYW'(V_RES - 1);

   // Integer bits must leave room for a fraction; grid must be non-empty.
   if (FP_INT >= FP_WIDTH || H_RES < 1 || V_RES < 1) begin : g_param_check
      $error("mandelbrot_scan: illegal parameter combination");
   end

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StDone} state_t;

   state_t              state_q, state_d;
   logic [FP_WIDTH-1:0] x0_q, x0_d;
   logic [FP_WIDTH-1:0] step_q, step_d;
   logic [FP_WIDTH-1:0] re_q, re_d;
   logic [FP_WIDTH-1:0] im_q, im_d;
   logic [PXW-1:0]      px_q, px_d;
   logic [PYW-1:0]      py_q, py_d;
   logic [ADDRW-1:0]    addr_q, addr_d;
   logic [ITERW-1:0]    data_q, data_d;
   logic                we_q, we_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                cs_q, cs_d;

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      step_d  = step_q;
      re_d    = re_q;
      im_d    = im_q;
      px_d    = px_q;
      py_d    = py_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = we_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cs_d    = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               x0_d    = x_start;
               step_d  = step;
               re_d    = x_start;
               im_d    = y_start;
               px_d    = '0;
               py_d    = '0;
               addr_d  = '0;
               busy_d  = 1'b1;
               cs_d    = 1'b1;  // pulse is visible during StIssue
               state_d = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (calc_done) begin
               data_d  = calc_iter;
               we_d    = 1'b1;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (fb_ready) begin
               we_d   = 1'b0;
               addr_d = addr_q + ADDRW'(1);
               if (px_q == PX_LAST && py_q == PY_LAST) begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end else if (px_q == PX_LAST) begin
                  px_d    = '0;
                  re_d    = x0_q;
                  py_d    = py_q + PYW'(1);
                  im_d    = im_q - step_q;
                  cs_d    = 1'b1;
                  state_d = StIssue;
               end else begin
                  px_d    = px_q + PXW'(1);
                  re_d    = re_q + step_q;
                  cs_d    = 1'b1;
                  state_d = StIssue;
               end
            end
         end
         StDone: begin
            // done_d defaults low, so done and busy fall together
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         x0_q    <= '0;
         step_q  <= '0;
         re_q    <= '0;
         im_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         step_q  <= step_d;
         re_q    <= re_d;
         im_q    <= im_d;
         px_q    <= px_d;
         py_q    <= py_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_q    <= cs_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign calc_start = cs_q;
   assign calc_re    = re_q;
   assign calc_im    = im_q;
   assign fb_we      = we_q;
   assign fb_addr    = addr_q;
   assign fb_data    = data_q;

endmodule
